// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  // Requester port indices: instruction side and data side.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the arbiter, bundled as one interface.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          rd0;
  logic          wr0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] rdata0;
  logic          ack0;

  logic          rd1;
  logic          wr1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] rdata1;
  logic          ack1;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          busy;
  logic          owner;

  // Arbiter side.
  modport slave (
    input  rd0, wr0, addr0, wdata0,
    input  rd1, wr1, addr1, wdata1,
    input  mem_rdata, mem_ready,
    output rdata0, ack0, rdata1, ack1,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  // Requesters plus memory, as seen from outside the arbiter.
  modport master (
    output rd0, wr0, addr0, wdata0,
    output rd1, wr1, addr1, wdata1,
    output mem_rdata, mem_ready,
    input  rdata0, ack0, rdata1, ack1,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between the two requesters with a bounded data-side
// priority. Purely combinational so it can be exercised on its own.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_CONSEC = 4,
  parameter int CW         = $clog2(MAX_CONSEC + 1)
) (
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic [CW-1:0] dcnt_i,
  output logic          valid_o,
  output logic          winner_o,
  output logic [CW-1:0] dcnt_o
);

  localparam logic [CW-1:0] MAXC = CW'(MAX_CONSEC);

  // Data side wins unless it has used up its run while the instruction side waits.
  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = PORT_I;
    dcnt_o   = dcnt_i;
    if (req1_i && (!req0_i || (dcnt_i < MAXC))) begin
      winner_o = PORT_D;
    end
    if (valid_o) begin
      if ((winner_o == PORT_D) && req0_i) begin
        dcnt_o = (dcnt_i < MAXC) ? dcnt_i + 1'b1 : dcnt_i;
      end else begin
        dcnt_o = '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-word memory port.
//
// state | meaning
// IDLE  | sample requests, latch the winner's transaction
// MEM   | mem_req held until mem_ready
// ACK   | one-cycle completion pulse to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_CONSEC + 1);

  arb_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] dcnt_q, dcnt_d;

  logic          pick_valid;
  logic          pick_winner;
  logic [CW-1:0] pick_dcnt;

  // A write strobe dominates a read strobe on the same port.
  mem_arb_pick #(
    .MAX_CONSEC (MAX_CONSEC),
    .CW         (CW)
  ) u_pick (
    .req0_i   (bus.rd0 | bus.wr0),
    .req1_i   (bus.rd1 | bus.wr1),
    .dcnt_i   (dcnt_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner),
    .dcnt_o   (pick_dcnt)
  );

  // State and all output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      owner_q     <= PORT_I;
      dcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      owner_q     <= owner_d;
      dcnt_q      <= dcnt_d;
    end
  end

  // Next state: grant in IDLE, wait for memory in MEM, pulse ack in ACK.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    owner_d     = owner_q;
    dcnt_d      = dcnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d   = pick_winner;
          dcnt_d    = pick_dcnt;
          mem_req_d = 1'b1;
          if (pick_winner == PORT_D) begin
            mem_we_d    = bus.wr1;
            mem_addr_d  = bus.addr1;
            mem_wdata_d = bus.wdata1;
          end else begin
            mem_we_d    = bus.wr0;
            mem_addr_d  = bus.addr0;
            mem_wdata_d = bus.wdata0;
          end
          state_d = MEM;
        end
      end
      MEM: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          if (owner_q == PORT_D) begin
            ack1_d = 1'b1;
            if (!mem_we_q) rdata1_d = bus.mem_rdata;
          end else begin
            ack0_d = 1'b1;
            if (!mem_we_q) rdata0_d = bus.mem_rdata;
          end
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
